// File: rtl/xge_pkg.sv
// xge_pkg
// Shared types for the 10GE transmit path.
//   XGE_DATA_W  : MAC packet data width
//   xge_mod_t   : valid-byte modulo carried with the eop word
//   pkt_word_t  : one packet word as held in an output stage
//   arb_state_t : transmit arbiter states
package xge_pkg;

    localparam int XGE_DATA_W = 64;

    typedef logic [2:0] xge_mod_t;

    typedef struct packed {
        logic [XGE_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        xge_mod_t              mod;
    } pkt_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/xge_rr_pick.sv
// xge_rr_pick
// Combinational round-robin priority picker. Finds the first set bit of
// elig_i starting at index ptr_i and searching upward, wrapping modulo N.
// Ports:
//   elig_i  [N-1:0]     : eligibility vector
//   ptr_i   [IDX_W-1:0] : index with highest priority (must be < N)
//   valid_o             : at least one eligible bit
//   idx_o   [IDX_W-1:0] : winning index (0 when valid_o is low)
module xge_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0]   sum_w;
    logic [IDX_W-1:0] cand_w;

    // Walk the N candidates in priority order; the extra sum bit lets the
    // wrap be done by a single conditional subtract for any N, not only
    // powers of two. The first hit wins, later hits are ignored.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum_w   = '0;
        cand_w  = '0;
        for (int k = 0; k < N; k++) begin
            sum_w = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum_w >= (IDX_W+1)'(N)) begin
                sum_w = sum_w - (IDX_W+1)'(N);
            end
            cand_w = sum_w[IDX_W-1:0];
            if (!valid_o && elig_i[cand_w]) begin
                valid_o = 1'b1;
                idx_o   = cand_w;
            end
        end
    end

endmodule

// File: rtl/xge_tx_arbiter.sv
// xge_tx_arbiter
// Packet-atomic round-robin arbiter sharing the MAC TX packet port between
// N_REQ streaming requesters, with a one-entry output stage that stalls on
// pkt_tx_full.
// Ports:
//   clk_156m25, reset_156m25_n        : core clock, synchronous active-low reset
//   req_val/sop/eop [N_REQ]           : per-requester word framing
//   req_mod  [N_REQ*3]                : per-requester byte modulo (eop words)
//   req_data [N_REQ*DATA_W]           : per-requester data
//   req_ready [N_REQ]                 : word accepted when req_val & req_ready
//   port_en  [N_REQ]                  : per-requester arbitration enable
//   pkt_tx_data/val/sop/eop/mod       : to MAC
//   pkt_tx_full                       : MAC FIFO full, no write while high
//   busy                              : a grant is active
//   grant_id                          : current or last granted requester
//   pkt_cnt                           : packets completed (eop accepted)
//   proto_err                         : one-cycle pulse on a sop framing violation
module xge_tx_arbiter
    import xge_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = XGE_DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic                      clk_156m25,
    input  logic                      reset_156m25_n,
    input  logic [N_REQ-1:0]          req_val,
    input  logic [N_REQ-1:0]          req_sop,
    input  logic [N_REQ-1:0]          req_eop,
    input  logic [N_REQ*3-1:0]        req_mod,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          port_en,
    output logic [DATA_W-1:0]         pkt_tx_data,
    output logic                      pkt_tx_val,
    output logic                      pkt_tx_sop,
    output logic                      pkt_tx_eop,
    output logic [2:0]                pkt_tx_mod,
    input  logic                      pkt_tx_full,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic [CNT_W-1:0]          pkt_cnt,
    output logic                      proto_err
);

    localparam int ID_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    pkt_word_t        stage_q, stage_d;
    logic             stage_val_q, stage_val_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;

    logic [N_REQ-1:0] eligible;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic             stage_ready;
    logic             tx_fire;
    logic             accept;
    logic             g_val;
    logic             g_sop;
    logic             g_eop;
    logic [ID_W-1:0]  next_ptr;

    assign eligible = port_en & req_val;

    xge_rr_pick #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .elig_i  (eligible),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // The stage can take a new word when it is empty or is being drained
    // in the same cycle; the MAC write is gated combinationally by full so a
    // word is never written while the MAC FIFO is full.
    assign stage_ready = !stage_val_q || !pkt_tx_full;
    assign tx_fire     = stage_val_q && !pkt_tx_full;

    assign g_val    = req_val[grant_q];
    assign g_sop    = req_sop[grant_q];
    assign g_eop    = req_eop[grant_q];
    assign accept   = (state_q == GRANT) && g_val && stage_ready;
    assign next_ptr = (grant_q == ID_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;

    // Only the granted requester ever sees ready, and only while the stage
    // has room; in IDLE nobody is ready, which enforces an idle gap between
    // packets.
    always_comb begin
        req_ready = '0;
        if (state_q == GRANT) begin
            req_ready[grant_q] = stage_ready;
        end
    end

    // Next-state logic. The stage drain is applied first so that an accept
    // in the same cycle overrides it and the stage stays full with the new
    // word. sop is regenerated from first_q rather than trusted from the
    // requester; a disagreement is reported through proto_err.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        stage_d     = stage_q;
        stage_val_d = stage_val_q;
        first_d     = first_q;
        cnt_d       = cnt_q;
        perr_d      = 1'b0;

        if (tx_fire) begin
            stage_val_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    first_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    stage_d.data = req_data[grant_q*DATA_W +: DATA_W];
                    stage_d.sop  = first_q;
                    stage_d.eop  = g_eop;
                    stage_d.mod  = req_mod[grant_q*3 +: 3];
                    stage_val_d  = 1'b1;
                    first_d      = 1'b0;
                    perr_d       = first_q ? !g_sop : g_sop;
                    if (g_eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything including the stage so the
    // MAC sees pkt_tx_val drop on the reset edge.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            stage_q     <= '0;
            stage_val_q <= 1'b0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            stage_q     <= stage_d;
            stage_val_q <= stage_val_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            perr_q      <= perr_d;
        end
    end

    assign pkt_tx_val  = tx_fire;
    assign pkt_tx_data = stage_q.data;
    assign pkt_tx_sop  = stage_q.sop;
    assign pkt_tx_eop  = stage_q.eop;
    assign pkt_tx_mod  = stage_q.mod;
    assign busy        = (state_q == GRANT);
    assign grant_id    = grant_q;
    assign pkt_cnt     = cnt_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// tb_xge_tx_arbiter
// Self-checking bench for xge_tx_arbiter (N_REQ=4): a table of per-cycle
// vectors for single packets, framing errors, port_en and MAC backpressure,
// followed by hand-written sequences for reset mid-packet and continuous
// round-robin traffic from all requesters.
`timescale 1ns/1ps
module tb_xge_tx_arbiter;

    localparam int N = 4;
    localparam int DW = 64;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_val;
    logic [N-1:0]    req_sop;
    logic [N-1:0]    req_eop;
    logic [N*3-1:0]  req_mod;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    port_en;
    logic [DW-1:0]   pkt_tx_data;
    logic            pkt_tx_val;
    logic            pkt_tx_sop;
    logic            pkt_tx_eop;
    logic [2:0]      pkt_tx_mod;
    logic            pkt_tx_full;
    logic            busy;
    logic [1:0]      grant_id;
    logic [31:0]     pkt_cnt;
    logic            proto_err;

    int nVectors;
    int nMiscompares;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  val;
        logic [3:0]  sop;
        logic [3:0]  eop;
        logic [2:0]  mod;
        int          tag;
        logic        full;
        logic [3:0]  eReady;
        logic        eVal;
        logic        eSop;
        logic        eEop;
        logic [2:0]  eMod;
        int          eLane;
        int          eTag;
        logic        eBusy;
        logic [1:0]  eGid;
        logic [31:0] eCnt;
        logic        ePerr;
    } vec_t;

    vec_t vecs[$];

    xge_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(32)) dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .req_val        (req_val),
        .req_sop        (req_sop),
        .req_eop        (req_eop),
        .req_mod        (req_mod),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .port_en        (port_en),
        .pkt_tx_data    (pkt_tx_data),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .pkt_tx_full    (pkt_tx_full),
        .busy           (busy),
        .grant_id       (grant_id),
        .pkt_cnt        (pkt_cnt),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data word that identifies both the requester lane and a word tag.
    function automatic logic [63:0] mkData(input int lane, input int tag);
        return {16'hC0DE, 8'(lane), 8'h00, 24'h000000, 8'(tag)};
    endfunction

    function automatic vec_t mk(input int en, input int val, input int sop, input int eop,
                                input int mod, input int tag, input int full,
                                input int eReady, input int eVal, input int eSop, input int eEop,
                                input int eMod, input int eLane, input int eTag,
                                input int eBusy, input int eGid, input int eCnt, input int ePerr);
        vec_t v;
        v.en = 4'(en);       v.val = 4'(val);      v.sop = 4'(sop);   v.eop = 4'(eop);
        v.mod = 3'(mod);     v.tag = tag;          v.full = 1'(full);
        v.eReady = 4'(eReady); v.eVal = 1'(eVal);  v.eSop = 1'(eSop); v.eEop = 1'(eEop);
        v.eMod = 3'(eMod);   v.eLane = eLane;      v.eTag = eTag;
        v.eBusy = 1'(eBusy); v.eGid = 2'(eGid);    v.eCnt = 32'(eCnt); v.ePerr = 1'(ePerr);
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one table row; every lane carries the same framing bits and mod,
    // with its own lane id embedded in the data.
    task automatic applyStimulus(input vec_t v);
        port_en     = v.en;
        req_val     = v.val;
        req_sop     = v.sop;
        req_eop     = v.eop;
        pkt_tx_full = v.full;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = mkData(i, v.tag);
            req_mod[i*3 +: 3]    = v.mod;
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        nVectors++;
        cmp($sformatf("row%0d.req_ready", idx), 64'(req_ready), 64'(v.eReady));
        cmp($sformatf("row%0d.pkt_tx_val", idx), 64'(pkt_tx_val), 64'(v.eVal));
        cmp($sformatf("row%0d.busy", idx), 64'(busy), 64'(v.eBusy));
        cmp($sformatf("row%0d.grant_id", idx), 64'(grant_id), 64'(v.eGid));
        cmp($sformatf("row%0d.pkt_cnt", idx), 64'(pkt_cnt), 64'(v.eCnt));
        cmp($sformatf("row%0d.proto_err", idx), 64'(proto_err), 64'(v.ePerr));
        if (v.eVal) begin
            cmp($sformatf("row%0d.pkt_tx_data", idx), pkt_tx_data, mkData(v.eLane, v.eTag));
            cmp($sformatf("row%0d.pkt_tx_sop", idx), 64'(pkt_tx_sop), 64'(v.eSop));
            cmp($sformatf("row%0d.pkt_tx_eop", idx), 64'(pkt_tx_eop), 64'(v.eEop));
            cmp($sformatf("row%0d.pkt_tx_mod", idx), 64'(pkt_tx_mod), 64'(v.eMod));
        end
    endtask

    task automatic checkResetState(input string where);
        nVectors++;
        cmp({where, ".pkt_tx_val"}, 64'(pkt_tx_val), 64'd0);
        cmp({where, ".pkt_tx_data"}, pkt_tx_data, 64'd0);
        cmp({where, ".pkt_tx_sop"}, 64'(pkt_tx_sop), 64'd0);
        cmp({where, ".pkt_tx_eop"}, 64'(pkt_tx_eop), 64'd0);
        cmp({where, ".pkt_tx_mod"}, 64'(pkt_tx_mod), 64'd0);
        cmp({where, ".req_ready"}, 64'(req_ready), 64'd0);
        cmp({where, ".busy"}, 64'(busy), 64'd0);
        cmp({where, ".grant_id"}, 64'(grant_id), 64'd0);
        cmp({where, ".pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        cmp({where, ".proto_err"}, 64'(proto_err), 64'd0);
    endtask

    // Main sequence: reset, table rows, reset mid-packet, then round-robin.
    initial begin
        int wc[N];
        logic [N-1:0] acc;
        int outIdx;
        int nGrants;
        logic prevBusy;
        int k;
        int w;
        int lane;

        nVectors     = 0;
        nMiscompares = 0;
        rst_n        = 1'b0;
        req_val      = '0;
        req_sop      = '0;
        req_eop      = '0;
        req_mod      = '0;
        req_data     = '0;
        port_en      = '1;
        pkt_tx_full  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Requester 0, three-word packet, mod 5 on eop.
        vecs.push_back(mk('hF,1,1,0,0,1,0, 0,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk('hF,1,1,0,0,1,0, 1,0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk('hF,1,0,0,0,2,0, 1,1,1,0,0,0,1, 1,0,0,0));
        vecs.push_back(mk('hF,1,0,1,5,3,0, 1,1,0,0,0,0,2, 1,0,0,0));
        vecs.push_back(mk('hF,0,0,0,0,0,0, 0,1,0,1,5,0,3, 0,0,1,0));
        vecs.push_back(mk('hF,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,1,0));
        // Requester 2: first word without sop, third word with a stray sop.
        vecs.push_back(mk('hF,4,0,0,0,4,0, 0,0,0,0,0,0,0, 0,0,1,0));
        vecs.push_back(mk('hF,4,0,0,0,4,0, 4,0,0,0,0,0,0, 1,2,1,0));
        vecs.push_back(mk('hF,4,0,0,0,5,0, 4,1,1,0,0,2,4, 1,2,1,1));
        vecs.push_back(mk('hF,4,4,0,0,6,0, 4,1,0,0,0,2,5, 1,2,1,0));
        vecs.push_back(mk('hF,4,0,4,3,7,0, 4,1,0,0,0,2,6, 1,2,1,1));
        vecs.push_back(mk('hF,0,0,0,0,0,0, 0,1,0,1,3,2,7, 0,2,2,0));
        vecs.push_back(mk('hF,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,2,2,0));
        // port_en[1]=0 with 0 and 1 requesting; port_en[0] cleared mid-packet.
        vecs.push_back(mk('hD,3,3,0,0,8,0, 0,0,0,0,0,0,0, 0,2,2,0));
        vecs.push_back(mk('hD,3,3,0,0,8,0, 1,0,0,0,0,0,0, 1,0,2,0));
        vecs.push_back(mk('hC,3,0,0,0,9,0, 1,1,1,0,0,0,8, 1,0,2,0));
        vecs.push_back(mk('hC,3,0,3,7,10,0, 1,1,0,0,0,0,9, 1,0,2,0));
        vecs.push_back(mk('hC,3,3,0,0,11,0, 0,1,0,1,7,0,10, 0,0,3,0));
        vecs.push_back(mk('hC,3,3,0,0,11,0, 0,0,0,0,0,0,0, 0,0,3,0));
        vecs.push_back(mk('hF,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,3,0));
        // Requester 1 with pkt_tx_full held for five cycles mid-packet.
        vecs.push_back(mk('hF,2,2,0,0,20,0, 0,0,0,0,0,0,0, 0,0,3,0));
        vecs.push_back(mk('hF,2,2,0,0,20,0, 2,0,0,0,0,0,0, 1,1,3,0));
        for (int r = 0; r < 5; r++) begin
            vecs.push_back(mk('hF,2,0,0,0,21,1, 0,0,0,0,0,0,0, 1,1,3,0));
        end
        vecs.push_back(mk('hF,2,0,0,0,21,0, 2,1,1,0,0,1,20, 1,1,3,0));
        vecs.push_back(mk('hF,2,0,2,1,22,0, 2,1,0,0,0,1,21, 1,1,3,0));
        vecs.push_back(mk('hF,0,0,0,0,0,0, 0,1,0,1,1,1,22, 0,1,4,0));
        vecs.push_back(mk('hF,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,1,4,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        // Reset mid-packet: requester 3 (rr pointer is now 2) gets two words in.
        @(negedge clk);
        applyStimulus(mk('hF,8,8,0,0,30,0, 0,0,0,0,0,0,0, 0,0,0,0));
        #1;
        nVectors++;
        cmp("rst_seq.busy_idle", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        nVectors++;
        cmp("rst_seq.grant_id", 64'(grant_id), 64'd3);
        cmp("rst_seq.req_ready", 64'(req_ready), 64'h8);
        @(negedge clk);
        applyStimulus(mk('hF,8,0,0,0,31,0, 0,0,0,0,0,0,0, 0,0,0,0));
        #1;
        nVectors++;
        cmp("rst_seq.word0_val", 64'(pkt_tx_val), 64'd1);
        cmp("rst_seq.word0_data", pkt_tx_data, mkData(3, 30));
        cmp("rst_seq.word0_sop", 64'(pkt_tx_sop), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nVectors++;
        cmp("rst_seq.word1_val", 64'(pkt_tx_val), 64'd1);
        cmp("rst_seq.word1_data", pkt_tx_data, mkData(3, 31));
        @(posedge clk);
        #1;
        checkResetState("rst_mid");
        @(negedge clk);
        rst_n   = 1'b1;
        req_val = '0;
        req_sop = '0;
        req_eop = '0;

        // All four requesters stream two 2-word packets each; expected MAC
        // order is lane 0,1,2,3,0,1,2,3 with no interleaving.
        for (int i = 0; i < N; i++) wc[i] = 0;
        outIdx   = 0;
        nGrants  = 0;
        prevBusy = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req_val[i]           = (wc[i] < 4);
                req_sop[i]           = (wc[i] % 2 == 0);
                req_eop[i]           = (wc[i] % 2 == 1);
                req_mod[i*3 +: 3]    = 3'(i);
                req_data[i*DW +: DW] = mkData(i, wc[i]);
            end
            #1;
            acc = req_val & req_ready;
            if (busy && !prevBusy) begin
                nVectors++;
                cmp($sformatf("rr.grant%0d", nGrants), 64'(grant_id), 64'(nGrants % N));
                nGrants++;
            end
            prevBusy = busy;
            if (pkt_tx_val) begin
                k    = outIdx / 2;
                w    = outIdx % 2;
                lane = k % N;
                nVectors++;
                cmp($sformatf("rr.word%0d.data", outIdx), pkt_tx_data, mkData(lane, 2*(k/N) + w));
                cmp($sformatf("rr.word%0d.sop", outIdx), 64'(pkt_tx_sop), 64'(w == 0));
                cmp($sformatf("rr.word%0d.eop", outIdx), 64'(pkt_tx_eop), 64'(w == 1));
                if (w == 1) cmp($sformatf("rr.word%0d.mod", outIdx), 64'(pkt_tx_mod), 64'(lane));
                cmp($sformatf("rr.word%0d.proto_err", outIdx), 64'(proto_err), 64'd0);
                outIdx++;
            end
            if (outIdx == 16) break;
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) wc[i]++;
            end
        end
        nVectors++;
        cmp("rr.words_seen", 64'(outIdx), 64'd16);
        cmp("rr.grants_seen", 64'(nGrants), 64'd8);
        cmp("rr.pkt_cnt", 64'(pkt_cnt), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/xge_tx_arbiter.md
Name: xge_tx_arbiter

Overview:
- Round-robin packet arbiter sharing the single MAC transmit packet interface (pkt_tx_*) between N_REQ streaming requesters.
- Sits in the 156.25 MHz core domain directly in front of the 10GE MAC TX packet port.
- Grants are packet-atomic: the winning requester keeps the port from its first word until its eop word is accepted.
- Honours pkt_tx_full through a one-entry stall-able output stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 64, packet data width; fixed to match the MAC port.
- CNT_W, 32, width of the sent-packet counter.

Ports:
- clk_156m25 input 1: core clock.
- reset_156m25_n input 1: reset.
- req_val input N_REQ: per-requester word valid.
- req_sop input N_REQ: per-requester start of packet.
- req_eop input N_REQ: per-requester end of packet.
- req_mod input N_REQ*3: per-requester valid-byte modulo, meaningful on eop.
- req_data input N_REQ*DATA_W: per-requester data.
- req_ready output N_REQ: word accepted when req_val and req_ready are both high.
- port_en input N_REQ: per-requester arbitration enable.
- pkt_tx_data output DATA_W: to MAC.
- pkt_tx_val output 1: to MAC.
- pkt_tx_sop output 1: to MAC.
- pkt_tx_eop output 1: to MAC.
- pkt_tx_mod output 3: to MAC.
- pkt_tx_full input 1: MAC TX FIFO full; no write while high.
- busy output 1: high in GRANT state.
- grant_id output $clog2(N_REQ): current or last granted requester.
- pkt_cnt output CNT_W: packets completed (eop accepted).
- proto_err output 1: one-cycle pulse on framing violation.

Behaviour:
- Interface: one clock, clk_156m25. reset_156m25_n is synchronous and active-low.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, stage empty, all pkt_tx_* 0, req_ready 0, busy 0, pkt_cnt 0, proto_err 0.
- States: IDLE and GRANT.
- IDLE arbitration:
  - eligible[i] = port_en[i] & req_val[i].
  - Winner is the first eligible index searching from rr_ptr upward, wrapping modulo N_REQ.
  - If any requester is eligible: register grant_id = winner and go to GRANT next cycle.
  - req_ready is all-zero in IDLE.
- Output stage:
  - stage_ready = !stage_valid | !pkt_tx_full.
  - pkt_tx_val = stage_valid & !pkt_tx_full (combinational on full). Data, sop, eop and mod come from stage registers.
  - The stage is drained when pkt_tx_val is high. It loads when a word is accepted; a simultaneous drain and load is allowed.
  - When the stage is drained and not reloaded, stage_valid clears to 0.
- GRANT:
  - req_ready[grant_id] = stage_ready; all other ready bits are 0.
  - Accept = req_val[g] & req_ready[g]. On accept the word enters the stage, so latency from requester to MAC is 1 cycle when not full.
- Framing rules:
  - First accepted word of a grant: pkt_tx_sop is forced to 1. If req_sop was 0, pulse proto_err.
  - Later words: pkt_tx_sop is forced to 0. If req_sop was 1, pulse proto_err.
  - eop and mod pass through unchanged.
- Accept with eop:
  - Return to IDLE next cycle.
  - rr_ptr = (grant_id+1) mod N_REQ.
  - pkt_cnt increments and wraps at 2^CNT_W.
  - A single-word packet (sop and eop together) completes in one accept.
- Spacing: at least one cycle of IDLE occurs between consecutive packets, including packets from the same requester.
- port_en deasserted mid-packet: the current packet completes; the requester is excluded from the next arbitration.
- pkt_tx_full held high: the stage holds its word, req_ready is 0, and no word is lost or duplicated.
- req_val low mid-packet: grant is held with no timeout; the stage drains normally.
- Reset mid-packet: all state clears on the next edge and pkt_tx_val drops. The partial packet at the MAC is truncated; the MAC flags it.

Decomposition:
- Shared package xge_pkg holds:
  - XGE_DATA_W = 64 and the 3-bit mod typedef.
  - typedef pkt_word_t {data, sop, eop, mod}.
  - The arbiter state enum {IDLE, GRANT}.
- One sub-module, xge_rr_pick: combinational round-robin priority picker taking an eligibility vector and rr_ptr, returning a valid flag and an index.

Test Plan:
- Single requester, 3-word packet, full=0:
  - Required: grant 1 cycle after req_val.
  - Required: MAC sees sop/data/eop 1 cycle after each accept; mod=5 preserved; pkt_cnt=1.
- All 4 requesters send 2-word packets continuously:
  - Required: grant order 0,1,2,3,0.
  - Required: packets never interleave; pkt_cnt=8 after 8 packets.
- pkt_tx_full high for 5 cycles mid-packet:
  - Required: pkt_tx_val=0 and req_ready=0 throughout.
  - Required: the held word appears exactly once after full drops.
- Requester 2 sends first word with sop=0, then a mid-packet word with sop=1:
  - Required: output sop=1 on word 0 and 0 on the later word.
  - Required: two proto_err pulses.
- port_en[1]=0 while 0 and 1 request:
  - Required: only requester 0 is granted.
  - Clearing port_en[0] mid-packet must let that packet finish.
- Assert reset_156m25_n=0 mid-packet:
  - Required: at the next edge all outputs are 0 and the state is IDLE.
  - Required: after release, arbitration restarts from requester 0.
